// File: rtl/inst_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage_pkg
//   Shared definitions for the IF stage and the next-PC logic that feeds it:
//   reset/NOP constants, fetch FSM encoding, next-PC operation codes and the
//   output-buffer entry layout.
// -----------------------------------------------------------------------------
package inst_fetch_stage_pkg;

    // Fetch PC after reset and the word presented to ID when nothing is buffered.
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    // Fetch handshake FSM.
    typedef enum logic [1:0] {
        S_REQ    = 2'd0,   // may issue a request
        S_WAIT   = 2'd1,   // request accepted, response pending
        S_CANCEL = 2'd2    // response pending but made stale by a redirect
    } fetch_state_t;

    // Next-PC operation select used by the next-PC logic upstream of this stage.
    typedef enum logic [1:0] {
        NPC_HOLD   = 2'd0,
        NPC_SEQ    = 2'd1,
        NPC_BRANCH = 2'd2,
        NPC_EXCEPT = 2'd3
    } npc_op_t;

    // One entry of the IF->ID output buffer.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

endpackage

// File: rtl/inst_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage_if
//   Split address/data instruction-memory handshake.
//     inst_req     : request valid (fetch stage -> memory)
//     inst_addr    : request address (fetch stage -> memory)
//     inst_addr_ok : request accepted this cycle (memory -> fetch stage)
//     inst_data_ok : response valid this cycle (memory -> fetch stage)
//     inst_rdata   : response instruction word (memory -> fetch stage)
//   master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface inst_fetch_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/inst_fetch_stage_if_out_buffer.sv
// -----------------------------------------------------------------------------
// if_out_buffer
//   One-entry IF->ID buffer holding {valid, pc, inst}.
//     clk, rst  : clock, synchronous active-high reset
//     flush     : discard contents (wins over a simultaneous write)
//     drain     : ID takes the entry this cycle
//     wr_en     : load {wr_pc, wr_inst}; a write together with a drain keeps
//                 the new entry valid
//     buf_valid : entry present
//     buf_pc    : entry PC, zero when empty
//     buf_inst  : entry word, INST_NOP when empty
// -----------------------------------------------------------------------------
module if_out_buffer #(
    parameter logic [31:0] INST_NOP = inst_fetch_stage_pkg::INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        drain,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_inst,
    output logic        buf_valid,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_inst
);
    import inst_fetch_stage_pkg::*;

    if_entry_t entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry <= '0;
        end else if (flush) begin
            entry.valid <= 1'b0;
        end else if (wr_en) begin
            entry <= '{valid: 1'b1, pc: wr_pc, inst: wr_inst};
        end else if (drain) begin
            entry.valid <= 1'b0;
        end
    end

    // Mask stale payload so ID only ever sees a NOP at PC 0 when empty.
    always_comb begin
        buf_valid = entry.valid;
        buf_pc    = entry.valid ? entry.pc   : '0;
        buf_inst  = entry.valid ? entry.inst : INST_NOP;
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage
//   IF stage of the in-order pipeline. Holds the fetch PC (reloaded from npc
//   every cycle), issues at most one outstanding instruction request, drops
//   responses made stale by a redirect and hands fetched words to ID through
//   a one-entry buffer.
//     clk, rst         : clock, synchronous active-high reset
//     npc              : next PC from the next-PC logic
//     redirect         : flush this cycle; npc carries the target
//     stall            : ID cannot accept an instruction this cycle
//     mem              : instruction-memory handshake (master side)
//     pc               : current fetch PC
//     req_inst_success : one-cycle pulse when a fetched word enters the buffer
//     if_valid/if_pc/if_inst : buffered instruction for ID
// -----------------------------------------------------------------------------
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = inst_fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] INST_NOP = inst_fetch_stage_pkg::INST_NOP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               npc,
    input  logic                      redirect,
    input  logic                      stall,
    inst_fetch_stage_if.master        mem,
    output logic [31:0]               pc,
    output logic                      req_inst_success,
    output logic                      if_valid,
    output logic [31:0]               if_pc,
    output logic [31:0]               if_inst
);
    import inst_fetch_stage_pkg::*;

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  req_pc;
    logic         fetch_req;
    logic         buf_wr;
    logic         accept;

    assign mem.inst_req  = fetch_req;
    assign mem.inst_addr = pc;
    assign accept        = fetch_req && mem.inst_addr_ok;

    // PC register and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            state  <= S_REQ;
            req_pc <= '0;
        end else begin
            pc    <= npc;
            state <= state_next;
            if (accept) begin
                req_pc <= pc;
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next       = state;
        fetch_req        = 1'b0;
        req_inst_success = 1'b0;
        buf_wr           = 1'b0;
        case (state)
            S_REQ: begin
                // Gating by redirect keeps a redirect from ever coinciding
                // with an accept; gating by a full stalled buffer guarantees
                // every response has somewhere to land.
                fetch_req = !rst && !stall && !redirect && !(if_valid && stall);
                if (fetch_req && mem.inst_addr_ok) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.inst_data_ok) begin
                    if (!redirect) begin
                        buf_wr           = 1'b1;
                        req_inst_success = !rst;
                    end
                    state_next = S_REQ;
                end else if (redirect) begin
                    state_next = S_CANCEL;
                end
            end
            S_CANCEL: begin
                // The pending response belongs to the old path; swallow it.
                if (mem.inst_data_ok) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    if_out_buffer #(
        .INST_NOP (INST_NOP)
    ) u_out_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .drain     (!stall),
        .wr_en     (buf_wr),
        .wr_pc     (req_pc),
        .wr_inst   (mem.inst_rdata),
        .buf_valid (if_valid),
        .buf_pc    (if_pc),
        .buf_inst  (if_inst)
    );

endmodule

// File: tb/tb_inst_fetch_stage.sv
module tb_inst_fetch_stage;

    localparam logic [31:0] P_RESET_PC = 32'h1c00_0000;
    localparam logic [31:0] P_NOP      = 32'h0340_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        redirect;
    logic        stall;
    logic [31:0] pc;
    logic        req_inst_success;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    // stimulus knobs
    logic [31:0] tgt;
    logic        accept_en;
    logic [3:0]  lat;

    int checks   = 0;
    int failures = 0;

    inst_fetch_stage_if bus();

    inst_fetch_stage #(
        .RESET_PC (P_RESET_PC),
        .INST_NOP (P_NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .npc              (npc),
        .redirect         (redirect),
        .stall            (stall),
        .mem              (bus),
        .pc               (pc),
        .req_inst_success (req_inst_success),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_inst          (if_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0280_0421 + (a - 32'h1c00_0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory: one response, programmable latency
    logic        m_pend;
    logic [3:0]  m_cnt;
    logic [31:0] m_addr;
    logic        mem_data_ok;

    assign mem_data_ok      = m_pend && (m_cnt == 4'd0);
    assign bus.inst_addr_ok = bus.inst_req && accept_en;
    assign bus.inst_data_ok = mem_data_ok;
    assign bus.inst_rdata   = mem_data_ok ? mem_word(m_addr) : 32'hdead_beef;

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0;
        end else begin
            if (m_pend && mem_data_ok)
                m_pend <= 1'b0;
            else if (m_pend)
                m_cnt <= m_cnt - 4'd1;
            if (bus.inst_req && bus.inst_addr_ok) begin
                m_pend <= 1'b1;
                m_cnt  <= lat - 4'd1;
                m_addr <= bus.inst_addr;
            end
        end
    end

    // ---------------- transaction-level reference model
    logic        m_init = 1'b0;
    logic [31:0] m_pc;
    logic        m_busy;       // a fetch is in flight
    logic        m_kill;       // the in-flight fetch belongs to an abandoned path
    logic [31:0] m_fetch_pc;
    logic        m_bv;
    logic [31:0] m_bpc;
    logic [31:0] m_binst;
    logic        e_req;
    logic        e_succ;

    always_comb begin
        e_req  = !rst && !m_busy && !stall && !redirect;
        e_succ = !rst && m_busy && !m_kill && mem_data_ok && !redirect;
        // next-PC logic: jump on redirect, advance on a retired fetch, else hold
        npc    = redirect ? tgt : (e_succ ? m_pc + 32'd4 : m_pc);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_init <= 1'b1;
            m_pc   <= P_RESET_PC;
            m_busy <= 1'b0;
            m_kill <= 1'b0;
            m_bv   <= 1'b0;
        end else begin
            m_pc <= npc;
            if (e_req && accept_en) begin
                m_busy     <= 1'b1;
                m_kill     <= 1'b0;
                m_fetch_pc <= m_pc;
            end else if (m_busy && mem_data_ok) begin
                m_busy <= 1'b0;
            end else if (m_busy && redirect) begin
                m_kill <= 1'b1;
            end
            if (redirect) begin
                m_bv <= 1'b0;
            end else if (e_succ) begin
                m_bv    <= 1'b1;
                m_bpc   <= m_fetch_pc;
                m_binst <= mem_word(m_fetch_pc);
            end else if (!stall) begin
                m_bv <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            check("cyc_pc", pc, m_pc);
            check("cyc_inst_req", {31'd0, bus.inst_req}, {31'd0, e_req});
            if (e_req) check("cyc_inst_addr", bus.inst_addr, m_pc);
            check("cyc_success", {31'd0, req_inst_success}, {31'd0, e_succ});
            check("cyc_if_valid", {31'd0, if_valid}, {31'd0, m_bv});
            check("cyc_if_pc", if_pc, m_bv ? m_bpc : 32'd0);
            check("cyc_if_inst", if_inst, m_bv ? m_binst : P_NOP);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence with literal expectations
    initial begin
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; tgt = '0;
        accept_en = 1'b1; lat = 4'd1;
        step(); step();
        @(negedge clk);
        check("rst_pc", pc, 32'h1c00_0000);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'h0340_0000);
        check("rst_inst_req", {31'd0, bus.inst_req}, 32'd0);
        check("rst_success", {31'd0, req_inst_success}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // first fetch, 1-cycle memory
        @(negedge clk);
        check("t1_req", {31'd0, bus.inst_req}, 32'd1);
        check("t1_addr", bus.inst_addr, 32'h1c00_0000);
        step(); @(negedge clk);
        check("t1_success", {31'd0, req_inst_success}, 32'd1);
        step(); @(negedge clk);
        check("t1_if_valid", {31'd0, if_valid}, 32'd1);
        check("t1_if_pc", if_pc, 32'h1c00_0000);
        check("t1_if_inst", if_inst, 32'h0280_0421);
        check("t1_req2", {31'd0, bus.inst_req}, 32'd1);
        lat = 4'd4;

        // redirect in S_WAIT, stale data 3 cycles later
        step(); redirect = 1'b1; tgt = 32'h1c00_0100;
        @(negedge clk);
        check("t2_success", {31'd0, req_inst_success}, 32'd0);
        check("t2_if_valid", {31'd0, if_valid}, 32'd0);
        step(); redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_success_w", {31'd0, req_inst_success}, 32'd0);
            check("t2_if_valid_w", {31'd0, if_valid}, 32'd0);
            step();
        end
        @(negedge clk);
        check("t2_req", {31'd0, bus.inst_req}, 32'd1);
        check("t2_addr", bus.inst_addr, 32'h1c00_0100);
        lat = 4'd2;

        // data_ok together with redirect
        step(); step(); redirect = 1'b1; tgt = 32'h1c00_0200;
        @(negedge clk);
        check("t3_success", {31'd0, req_inst_success}, 32'd0);
        step(); redirect = 1'b0;
        @(negedge clk);
        check("t3_if_valid", {31'd0, if_valid}, 32'd0);
        check("t3_addr", bus.inst_addr, 32'h1c00_0200);
        check("t3_req", {31'd0, bus.inst_req}, 32'd1);
        lat = 4'd1;

        // stall with a full buffer
        step(); @(negedge clk);
        check("t4_success", {31'd0, req_inst_success}, 32'd1);
        step(); stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_req_stall", {31'd0, bus.inst_req}, 32'd0);
            check("t4_if_valid", {31'd0, if_valid}, 32'd1);
            check("t4_if_pc", if_pc, 32'h1c00_0200);
            check("t4_if_inst", if_inst, 32'h0280_0621);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        check("t4_req_release", {31'd0, bus.inst_req}, 32'd1);
        check("t4_addr_release", bus.inst_addr, 32'h1c00_0204);
        step(); @(negedge clk);
        check("t4_drained", {31'd0, if_valid}, 32'd0);
        check("t4_success2", {31'd0, req_inst_success}, 32'd1);
        accept_en = 1'b0; lat = 4'd3;

        // addr_ok withheld 5 cycles
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_req_held", {31'd0, bus.inst_req}, 32'd1);
            check("t5_addr_held", bus.inst_addr, 32'h1c00_0208);
            step();
        end
        accept_en = 1'b1;
        @(negedge clk);
        check("t5_req_accept", {31'd0, bus.inst_req}, 32'd1);
        step(); @(negedge clk);
        check("t5_wait_req", {31'd0, bus.inst_req}, 32'd0);

        // reset in the middle of S_WAIT
        step(); rst = 1'b1;
        @(negedge clk);
        check("t6_req_in_rst", {31'd0, bus.inst_req}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_pc", pc, 32'h1c00_0000);
        check("t6_if_valid", {31'd0, if_valid}, 32'd0);
        check("t6_success", {31'd0, req_inst_success}, 32'd0);
        check("t6_req", {31'd0, bus.inst_req}, 32'd1);
        check("t6_addr", bus.inst_addr, 32'h1c00_0000);

        // free-running tail, model-checked only
        lat = 4'd2;
        for (int i = 0; i < 12; i++) begin
            step();
            stall = (i == 5) || (i == 6);
        end
        stall = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
